pin_entry_ctrl: RTL and testbench
=================================

Name: pin_entry_ctrl

Overview:
- Sequences keypad key events into a 4-digit PIN packet (pinPac_t) for the door-lock datapath.
- Accepts digit, clear and enter keys; emits one-cycle-valid packets; discards partial entries after an inactivity timeout.
- Sits between the keypad decoder and the lock/compare FSM, clocked on the system clock.

Parameters:
- TIMEOUT_CYCLES, 250_000_000, clock cycles of inactivity before a partial entry is discarded (5 s at 50 MHz); legal range 2..2^32-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- key_valid  input  1  one-cycle pulse; key_code is valid.
- key_code  input  4  0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored.
- pin_out  output  17  pinPac_t {status, digit1..digit4}; held between emits.
- pin_valid  output  1  one-cycle pulse; pin_out is new.
- digit_count  output  3  digits currently buffered, 0..4.
- timeout  output  1  one-cycle pulse when a partial entry is discarded.
- busy  output  1  high in ENTRY and EMIT.

Behaviour:
- Reset values: pin_out = {0, F, F, F, F}; pin_valid = 0; digit_count = 0; timeout = 0; busy = 0; state = IDLE; inactivity counter = 0.
- States:
  - IDLE: digit key -> store in digit1, count = 1, go to ENTRY. Enter and clear are ignored.
  - ENTRY, digit key: if count < 4, store in digit[count+1] and increment count. A 5th digit is ignored, but it still restarts the timer.
  - ENTRY, clear key: empty the buffer (all F), count = 0, return to IDLE.
  - ENTRY, enter key: go to EMIT. pin_out.status = 1 if count == 4, else 0. Unfilled digits read 4'hF.
  - ENTRY, timer expiry: reaching TIMEOUT_CYCLES-1 with no key -> timeout pulse, buffer cleared, go to IDLE. pin_out is unchanged.
  - EMIT (one cycle): pin_valid = 1, buffer cleared, count = 0, go to IDLE. key_valid in EMIT is dropped.
- Latency: enter sampled at edge N -> pin_out updated and pin_valid high in the cycle after edge N; IDLE at edge N+1.
- Inactivity counter: runs only in ENTRY; zeroed by any key_valid, including ignored codes.
- Simultaneous key_valid and expiry: the key wins. It is processed, the counter restarts, and no timeout pulse is produced.
- Ignored codes 4'hC-4'hF: no state change except the counter restart.
- Reset asserted mid-entry or mid-emit: immediate return to reset values; no pin_valid pulse is produced.
- digit_count is registered and reflects keys accepted through the previous edge.

Optional Feature:
- Macro PIN_BACKSPACE_EN.
- Defined: key 4'hA in ENTRY removes only the last digit (set to F, count decremented). If count becomes 0, go to IDLE. key_code 4'hC acts as full clear.
- Undefined: 4'hA is full clear as specified above; 4'hC is ignored.

Decomposition:
- Package pin_pkg holds: pinPac_t; the KEY_CLEAR, KEY_ENTER and KEY_FULLCLR constants; DIGIT_BLANK = 4'hF; the state enum (IDLE, ENTRY, EMIT).
- One sub-module, inactivity_timer: parameter TIMEOUT_CYCLES; inputs clock, reset, run, restart; output expired pulse.

Test Plan:
- TIMEOUT_CYCLES = 20. Keys 1, 2, 3, 4, enter -> pin_valid for exactly 1 cycle, the cycle after enter; pin_out = {1, 1, 2, 3, 4}; digit_count returns to 0.
- Keys 7, 5, enter -> pin_out = {0, 7, 5, F, F}, pin_valid pulse.
- Keys 1-6 then enter -> {1, 1, 2, 3, 4}; 5th and 6th digits dropped.
- Key 9, then 20 idle cycles -> timeout pulse on cycle 20, busy falls, no pin_valid. Repeat with a key arriving on cycle 19 -> no timeout.
- Keys 3, 8, clear, 4, 4, 4, 4, enter -> {1, 4, 4, 4, 4}. With PIN_BACKSPACE_EN: keys 3, 8, 4'hA, 1, 2, 3, enter -> {1, 3, 1, 2, 3}.
- Reset pulsed after keys 1, 2 -> all outputs at reset values; a following enter in IDLE gives no pin_valid.

Source files
------------

// File: rtl/pin_entry_ctrl_pkg.sv
// Shared types and key codes for the keypad PIN entry block.
// Optional backspace behaviour is enabled with PIN_BACKSPACE_EN.
package pin_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] KEY_FULLCLR = 4'hC;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    EMIT
  } state_t;

  localparam pinPac_t PIN_RESET = '{
    status: 1'b0,
    digit1: DIGIT_BLANK,
    digit2: DIGIT_BLANK,
    digit3: DIGIT_BLANK,
    digit4: DIGIT_BLANK
  };

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_ctrl_timer.sv
// Inactivity timer: counts while run is high, zeroed by restart.
// expired is a combinational pulse on the last count of an idle run.
module inactivity_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_cnt;
  logic        w_hit;

  // A key on the expiry cycle suppresses the pulse.
  assign w_hit   = run && !restart && (r_cnt == LAST);
  assign expired = w_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || restart || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pin_entry_ctrl.sv
// Keypad key sequencer producing 4-digit PIN packets.
// Define PIN_BACKSPACE_EN to make 4'hA a backspace and 4'hC a full clear.
module pin_entry_ctrl
  import pin_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [16:0] pin_out,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic        timeout,
  output logic        busy
);

  state_t     r_state;
  logic [3:0] r_dig [4];
  logic [2:0] r_cnt;
  pinPac_t    r_pin;
  logic       r_valid;
  logic       r_timeout;
  logic       r_busy;
  logic       w_expired;
  logic       w_run;

  assign w_run       = (r_state == ENTRY);
  assign pin_out     = r_pin;
  assign pin_valid   = r_valid;
  assign digit_count = r_cnt;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

`ifdef PIN_BACKSPACE_EN
  logic [1:0] w_last;
  assign w_last = 2'(r_cnt - 3'd1);
`endif

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .run    (w_run),
    .restart(key_valid),
    .expired(w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_pin     <= PIN_RESET;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (key_valid && is_digit(key_code)) begin
            r_dig[0] <= key_code;
            r_cnt    <= 3'd1;
            r_state  <= ENTRY;
            r_busy   <= 1'b1;
          end
        end
        ENTRY: begin
          if (key_valid) begin
            unique case (1'b1)
              is_digit(key_code): begin
                if (r_cnt < 3'd4) begin
                  r_dig[r_cnt[1:0]] <= key_code;
                  r_cnt             <= r_cnt + 3'd1;
                end
              end
              (key_code == KEY_ENTER): begin
                r_pin <= '{
                  status: (r_cnt == 3'd4),
                  digit1: r_dig[0],
                  digit2: r_dig[1],
                  digit3: r_dig[2],
                  digit4: r_dig[3]
                };
                r_valid <= 1'b1;
                r_state <= EMIT;
              end
`ifdef PIN_BACKSPACE_EN
              (key_code == KEY_CLEAR): begin
                r_dig[w_last] <= DIGIT_BLANK;
                r_cnt         <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end
              (key_code == KEY_FULLCLR): begin
                for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
                r_cnt   <= 3'd0;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
`else
              (key_code == KEY_CLEAR): begin
                for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
                r_cnt   <= 3'd0;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
`endif
              default: ;
            endcase
          end else if (w_expired) begin
            for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
            r_cnt     <= 3'd0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
        end
        EMIT: begin
          for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
          r_cnt   <= 3'd0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl with TIMEOUT_CYCLES = 20.
// Vector table for packet sequences, hand sequences for timer and reset.
module tb_pin_entry_ctrl;

  localparam int unsigned TMO = 20;

  logic        clock;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [16:0] pin_out;
  logic        pin_valid;
  logic [2:0]  digit_count;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pin_entry_ctrl #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pin_out    (pin_out),
    .pin_valid  (pin_valid),
    .digit_count(digit_count),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic [16:0] pin;
    logic        vld;
    logic [2:0]  cnt;
    logic        to;
    logic        bsy;
  } vec_t;

  vec_t vq[$];

  localparam logic [16:0] RST_PIN = 17'h0FFFF;

  function automatic logic [16:0] pk(logic s, logic [3:0] a, logic [3:0] b,
                                     logic [3:0] c, logic [3:0] d);
    return {s, a, b, c, d};
  endfunction

  task automatic add(logic kv, logic [3:0] kc, logic [16:0] pin, logic vld,
                     logic [2:0] cnt, logic bsy);
    vec_t v;
    v.kv  = kv;
    v.kc  = kc;
    v.pin = pin;
    v.vld = vld;
    v.cnt = cnt;
    v.to  = 1'b0;
    v.bsy = bsy;
    vq.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic kv, logic [3:0] kc);
    @(negedge clock);
    key_valid = kv;
    key_code  = kc;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(string tag, logic [16:0] pin, logic vld,
                         logic [2:0] cnt, logic to, logic bsy);
    chk({tag, ".pin_out"}, 32'(pin_out), 32'(pin));
    chk({tag, ".pin_valid"}, 32'(pin_valid), 32'(vld));
    chk({tag, ".digit_count"}, 32'(digit_count), 32'(cnt));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  logic [16:0] p1234;
  logic [16:0] last_pin;

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    p1234     = pk(1'b1, 4'h1, 4'h2, 4'h3, 4'h4);

    // 1,2,3,4,enter
    add(1, 4'h1, RST_PIN, 0, 3'd1, 1);
    add(1, 4'h2, RST_PIN, 0, 3'd2, 1);
    add(1, 4'h3, RST_PIN, 0, 3'd3, 1);
    add(1, 4'h4, RST_PIN, 0, 3'd4, 1);
    add(1, 4'hB, p1234, 1, 3'd4, 1);
    add(0, 4'h0, p1234, 0, 3'd0, 0);
    add(0, 4'h0, p1234, 0, 3'd0, 0);
    // enter and clear ignored in IDLE
    add(1, 4'hB, p1234, 0, 3'd0, 0);
    add(1, 4'hA, p1234, 0, 3'd0, 0);
    // 7,5,enter with an ignored code in between
    add(1, 4'h7, p1234, 0, 3'd1, 1);
    add(1, 4'hE, p1234, 0, 3'd1, 1);
    add(1, 4'h5, p1234, 0, 3'd2, 1);
    add(1, 4'hB, pk(1'b0, 4'h7, 4'h5, 4'hF, 4'hF), 1, 3'd2, 1);
    add(0, 4'h0, pk(1'b0, 4'h7, 4'h5, 4'hF, 4'hF), 0, 3'd0, 0);
    // key in EMIT dropped: 1,enter,then 9 during EMIT
    add(1, 4'h1, pk(1'b0, 4'h7, 4'h5, 4'hF, 4'hF), 0, 3'd1, 1);
    add(1, 4'hB, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 1, 3'd1, 1);
    add(1, 4'h9, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd0, 0);
    // 1..6,enter: extra digits dropped
    add(1, 4'h1, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd1, 1);
    add(1, 4'h2, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd2, 1);
    add(1, 4'h3, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd3, 1);
    add(1, 4'h4, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd4, 1);
    add(1, 4'h5, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd4, 1);
    add(1, 4'h6, pk(1'b0, 4'h1, 4'hF, 4'hF, 4'hF), 0, 3'd4, 1);
    add(1, 4'hB, p1234, 1, 3'd4, 1);
    add(0, 4'h0, p1234, 0, 3'd0, 0);
`ifdef PIN_BACKSPACE_EN
    add(1, 4'h3, p1234, 0, 3'd1, 1);
    add(1, 4'h8, p1234, 0, 3'd2, 1);
    add(1, 4'hA, p1234, 0, 3'd1, 1);
    add(1, 4'h1, p1234, 0, 3'd2, 1);
    add(1, 4'h2, p1234, 0, 3'd3, 1);
    add(1, 4'h3, p1234, 0, 3'd4, 1);
    add(1, 4'hB, pk(1'b1, 4'h3, 4'h1, 4'h2, 4'h3), 1, 3'd4, 1);
    add(0, 4'h0, pk(1'b1, 4'h3, 4'h1, 4'h2, 4'h3), 0, 3'd0, 0);
`else
    add(1, 4'h3, p1234, 0, 3'd1, 1);
    add(1, 4'h8, p1234, 0, 3'd2, 1);
    add(1, 4'hA, p1234, 0, 3'd0, 0);
    add(1, 4'h4, p1234, 0, 3'd1, 1);
    add(1, 4'h4, p1234, 0, 3'd2, 1);
    add(1, 4'h4, p1234, 0, 3'd3, 1);
    add(1, 4'h4, p1234, 0, 3'd4, 1);
    add(1, 4'hB, pk(1'b1, 4'h4, 4'h4, 4'h4, 4'h4), 1, 3'd4, 1);
    add(0, 4'h0, pk(1'b1, 4'h4, 4'h4, 4'h4, 4'h4), 0, 3'd0, 0);
`endif

    #12;
    chk_all("reset", RST_PIN, 0, 3'd0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].kv, vq[i].kc);
      chk_all($sformatf("vec%0d", i), vq[i].pin, vq[i].vld, vq[i].cnt,
              vq[i].to, vq[i].bsy);
    end
    last_pin = vq[vq.size()-1].pin;

    // timeout after 20 idle cycles
    drive(1, 4'h9);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 4'h0);
      chk($sformatf("tmo.timeout%0d", k), 32'(timeout), 32'(k == 20));
      chk($sformatf("tmo.busy%0d", k), 32'(busy), 32'(k < 20));
      chk($sformatf("tmo.valid%0d", k), 32'(pin_valid), 32'd0);
    end
    chk("tmo.pin", 32'(pin_out), 32'(last_pin));
    chk("tmo.cnt", 32'(digit_count), 32'd0);
    drive(0, 4'h0);
    chk("tmo.pulse_end", 32'(timeout), 32'd0);

    // key on cycle 19 restarts the timer
    drive(1, 4'h9);
    for (int k = 1; k <= 18; k++) drive(0, 4'h0);
    drive(1, 4'h1);
    chk("rst19.cnt", 32'(digit_count), 32'd2);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 4'h0);
      chk($sformatf("rst19.timeout%0d", k), 32'(timeout), 32'(k == 20));
    end

    // ignored key on the expiry cycle wins over the timeout
    drive(1, 4'h9);
    for (int k = 1; k <= 19; k++) drive(0, 4'h0);
    drive(1, 4'hD);
    chk("tie.timeout", 32'(timeout), 32'd0);
    chk("tie.busy", 32'(busy), 32'd1);
    chk("tie.cnt", 32'(digit_count), 32'd1);
    drive(0, 4'h0);
    chk("tie.timeout_next", 32'(timeout), 32'd0);
    drive(1, 4'hA);
    chk("tie.clear_busy", 32'(busy), 32'd0);

    // async reset mid-entry, then enter in IDLE
    drive(1, 4'h1);
    drive(1, 4'h2);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_entry", RST_PIN, 0, 3'd0, 0, 0);
    @(negedge clock);
    reset     = 1'b0;
    key_valid = 1'b0;
    drive(1, 4'hB);
    chk_all("rst_enter", RST_PIN, 0, 3'd0, 0, 0);
    drive(0, 4'h0);
    chk("rst_enter.valid2", 32'(pin_valid), 32'd0);

    // async reset during EMIT kills the pulse
    drive(1, 4'h6);
    drive(1, 4'hB);
    chk("emit.valid", 32'(pin_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_all("rst_emit", RST_PIN, 0, 3'd0, 0, 0);
    @(negedge clock);
    reset     = 1'b0;
    key_valid = 1'b0;
    drive(0, 4'h0);
    chk_all("rst_emit.after", RST_PIN, 0, 3'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
